// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: synchronises NMI/IRQ pins, arbitrates RESET/NMI/BRK/IRQ at
// instruction boundaries and sequences the service window for the microcode sequencer.
module interrupt_arbiter #(
  parameter int          SYNC_STAGES    = 2,
  parameter int          SERVICE_CYCLES = 7,
  parameter int          SET_I_CYCLE    = 5,
  parameter logic [15:0] RST_VEC        = 16'hFFFC,
  parameter logic [15:0] NMI_VEC        = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC        = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        psr_i,
  input  logic        instr_boundary,
  input  logic        brk_op,
  input  logic        seq_ack,
  output logic        int_req,
  output logic [2:0]  int_kind,
  output logic [15:0] vec_addr,
  output logic        break_set,
  output logic        set_i,
  output logic        suppress_write,
  output logic        svc_done
);

  localparam int            CW        = $clog2(SERVICE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SERVICE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SET_I = CW'(SET_I_CYCLE);

  localparam logic [2:0] KIND_NONE  = 3'd0;
  localparam logic [2:0] KIND_RESET = 3'd1;
  localparam logic [2:0] KIND_NMI   = 3'd2;
  localparam logic [2:0] KIND_BRK   = 3'd3;
  localparam logic [2:0] KIND_IRQ   = 3'd4;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] nmi_sync;
  logic [SYNC_STAGES-1:0] irq_sync;
  logic                   nmi_prev;
  logic                   nmi_pending;
  logic                   reset_pending;
  logic [CW-1:0]          count;

  logic        nmi_s;
  logic        irq_s;
  logic        nmi_fall;
  logic        irq_go;
  logic        arb_any;
  logic [2:0]  arb_kind;
  logic [15:0] arb_vec;
  logic        arb_break;

  assign nmi_s    = nmi_sync[SYNC_STAGES-1];
  assign irq_s    = irq_sync[SYNC_STAGES-1];
  assign nmi_fall = nmi_prev & ~nmi_s;
  assign irq_go   = ~irq_s & ~psr_i;

  // Fixed-priority pick; an NMI that lands on a BRK opcode still reports B=1.
  always_comb begin
    arb_any   = reset_pending | nmi_pending | brk_op | irq_go;
    arb_kind  = KIND_NONE;
    arb_vec   = IRQ_VEC;
    arb_break = 1'b0;
    if (reset_pending) begin
      arb_kind = KIND_RESET;
      arb_vec  = RST_VEC;
    end else if (nmi_pending) begin
      arb_kind  = KIND_NMI;
      arb_vec   = NMI_VEC;
      arb_break = brk_op;
    end else if (brk_op) begin
      arb_kind  = KIND_BRK;
      arb_break = 1'b1;
    end else if (irq_go) begin
      arb_kind = KIND_IRQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      nmi_sync       <= '1;
      irq_sync       <= '1;
      nmi_prev       <= 1'b1;
      nmi_pending    <= 1'b0;
      reset_pending  <= 1'b1;
      count          <= '0;
      int_req        <= 1'b0;
      int_kind       <= KIND_NONE;
      vec_addr       <= RST_VEC;
      break_set      <= 1'b0;
      set_i          <= 1'b0;
      suppress_write <= 1'b0;
      svc_done       <= 1'b0;
    end else begin
      nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], nmi_n};
      irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq_n};
      nmi_prev <= nmi_s;
      set_i    <= 1'b0;
      svc_done <= 1'b0;
      if (nmi_fall)
        nmi_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (instr_boundary && arb_any) begin
            state     <= REQ;
            int_req   <= 1'b1;
            int_kind  <= arb_kind;
            vec_addr  <= arb_vec;
            break_set <= arb_break;
          end
        end
        REQ: begin
          if (seq_ack) begin
            state          <= SERVICE;
            int_req        <= 1'b0;
            count          <= '0;
            suppress_write <= (int_kind == KIND_RESET);
            set_i          <= (CNT_SET_I == '0);
            if (int_kind == KIND_RESET)
              reset_pending <= 1'b0;
            // A fresh edge arriving with the ack must not be lost.
            if (int_kind == KIND_NMI && !nmi_fall)
              nmi_pending <= 1'b0;
          end
        end
        SERVICE: begin
          if (count == CNT_LAST) begin
            state          <= IDLE;
            int_kind       <= KIND_NONE;
            suppress_write <= 1'b0;
          end else begin
            count    <= count + CW'(1);
            set_i    <= ((count + CW'(1)) == CNT_SET_I);
            svc_done <= ((count + CW'(1)) == CNT_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter with a cycle-level reference model checked
// every cycle, plus literal expectations at the interesting points of each scenario.
module tb_interrupt_arbiter;

  localparam int          SS      = 2;
  localparam int          SVC     = 7;
  localparam int          SETI    = 5;
  localparam logic [15:0] RST_VEC = 16'hFFFC;
  localparam logic [15:0] NMI_VEC = 16'hFFFA;
  localparam logic [15:0] IRQ_VEC = 16'hFFFE;

  logic        clk;
  logic        rst;
  logic        nmi_n;
  logic        irq_n;
  logic        psr_i;
  logic        instr_boundary;
  logic        brk_op;
  logic        seq_ack;
  logic        int_req;
  logic [2:0]  int_kind;
  logic [15:0] vec_addr;
  logic        break_set;
  logic        set_i;
  logic        suppress_write;
  logic        svc_done;

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  interrupt_arbiter #(
    .SYNC_STAGES(SS), .SERVICE_CYCLES(SVC), .SET_I_CYCLE(SETI),
    .RST_VEC(RST_VEC), .NMI_VEC(NMI_VEC), .IRQ_VEC(IRQ_VEC)
  ) dut (
    .clk(clk), .rst(rst), .nmi_n(nmi_n), .irq_n(irq_n), .psr_i(psr_i),
    .instr_boundary(instr_boundary), .brk_op(brk_op), .seq_ack(seq_ack),
    .int_req(int_req), .int_kind(int_kind), .vec_addr(vec_addr),
    .break_set(break_set), .set_i(set_i), .suppress_write(suppress_write),
    .svc_done(svc_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: pins seen through a plain delay line, service tracked as
  // elapsed cycles since the ack rather than as a state machine.
  logic        nmi_hist [0:SS];
  logic        irq_hist [0:SS];
  bit          m_req, m_serving, m_rst_pend, m_nmi_pend, m_break;
  int          m_elapsed;
  logic [2:0]  m_kind;
  logic [15:0] m_vec;

  always @(posedge clk) begin
    bit fall, irq_go;
    if (rst) begin
      m_req = 0; m_serving = 0; m_rst_pend = 1; m_nmi_pend = 0;
      m_break = 0; m_elapsed = 0; m_kind = 0; m_vec = RST_VEC;
      for (int i = 0; i <= SS; i++) begin
        nmi_hist[i] = 1'b1;
        irq_hist[i] = 1'b1;
      end
    end else begin
      fall   = nmi_hist[SS] && !nmi_hist[SS-1];
      irq_go = !irq_hist[SS-1] && !psr_i;
      if (m_serving) begin
        if (m_elapsed == SVC - 1) begin
          m_serving = 0;
          m_kind    = 0;
        end else begin
          m_elapsed = m_elapsed + 1;
        end
      end else if (m_req) begin
        if (seq_ack) begin
          m_req = 0; m_serving = 1; m_elapsed = 0;
          if (m_kind == 3'd1) m_rst_pend = 0;
          if (m_kind == 3'd2) m_nmi_pend = 0;
        end
      end else if (instr_boundary) begin
        if (m_rst_pend) begin
          m_req = 1; m_kind = 3'd1; m_vec = RST_VEC; m_break = 0;
        end else if (m_nmi_pend) begin
          m_req = 1; m_kind = 3'd2; m_vec = NMI_VEC; m_break = brk_op;
        end else if (brk_op) begin
          m_req = 1; m_kind = 3'd3; m_vec = IRQ_VEC; m_break = 1;
        end else if (irq_go) begin
          m_req = 1; m_kind = 3'd4; m_vec = IRQ_VEC; m_break = 0;
        end
      end
      if (fall) m_nmi_pend = 1;
      for (int i = SS; i > 0; i--) begin
        nmi_hist[i] = nmi_hist[i-1];
        irq_hist[i] = irq_hist[i-1];
      end
      nmi_hist[0] = nmi_n;
      irq_hist[0] = irq_n;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("int_req",   16'(int_req),   16'(m_req));
      checkOutput("int_kind",  16'(int_kind),  16'(m_kind));
      checkOutput("vec_addr",  vec_addr,       m_vec);
      checkOutput("break_set", 16'(break_set), 16'(m_break));
      checkOutput("set_i",     16'(set_i),     16'(m_serving && m_elapsed == SETI));
      checkOutput("svc_done",  16'(svc_done),  16'(m_serving && m_elapsed == SVC - 1));
      checkOutput("suppress",  16'(suppress_write), 16'(m_serving && m_kind == 3'd1));
    end
  end

  task automatic applyStimulus(input logic r, input logic b, input logic k, input logic a);
    rst = r; instr_boundary = b; brk_op = k; seq_ack = a;
    @(negedge clk);
    rst = 1'b0; instr_boundary = 1'b0; brk_op = 1'b0; seq_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic runService();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idle(SVC);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nmi_n = 1'b1; irq_n = 1'b1; psr_i = 1'b1;
    rst = 1'b1; instr_boundary = 1'b0; brk_op = 1'b0; seq_ack = 1'b0;

    // 1: reset request and its service window
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checking = 1;
    checkOutput("rst_int_req", 16'(int_req), 16'h0);
    checkOutput("rst_kind", 16'(int_kind), 16'h0);
    checkOutput("rst_vec", vec_addr, 16'hFFFC);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_req", 16'(int_req), 16'h1);
    checkOutput("t1_kind", 16'(int_kind), 16'h1);
    checkOutput("t1_vec", vec_addr, 16'hFFFC);
    idle(1);
    checkOutput("t1_req_hold", 16'(int_req), 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 7; c++) begin
      checkOutput("t1_suppress", 16'(suppress_write), 16'h1);
      checkOutput("t1_set_i", 16'(set_i), (c == 5) ? 16'h1 : 16'h0);
      checkOutput("t1_done", 16'(svc_done), (c == 6) ? 16'h1 : 16'h0);
      idle(1);
    end
    checkOutput("t1_exit_suppress", 16'(suppress_write), 16'h0);
    checkOutput("t1_exit_kind", 16'(int_kind), 16'h0);

    // 2: IRQ masked by I, then taken once I clears; stray ack in IDLE is ignored
    irq_n = 1'b0;
    idle(3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_masked", 16'(int_req), 16'h0);
    psr_i = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_kind", 16'(int_kind), 16'h4);
    checkOutput("t2_vec", vec_addr, 16'hFFFE);
    checkOutput("t2_break", 16'(break_set), 16'h0);
    irq_n = 1'b1; psr_i = 1'b1;
    runService();

    // 3: NMI edge timing and single service
    nmi_n = 1'b0;
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_too_early", 16'(int_req), 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_kind", 16'(int_kind), 16'h2);
    checkOutput("t3_vec", vec_addr, 16'hFFFA);
    runService();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_no_retrigger", 16'(int_req), 16'h0);
    nmi_n = 1'b1;
    idle(3);

    // 4: BRK hijacked by NMI, then a plain BRK
    nmi_n = 1'b0;
    idle(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_kind", 16'(int_kind), 16'h2);
    checkOutput("t4_vec", vec_addr, 16'hFFFA);
    checkOutput("t4_break", 16'(break_set), 16'h1);
    runService();
    checkOutput("t4_break_held", 16'(break_set), 16'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_brk_kind", 16'(int_kind), 16'h3);
    checkOutput("t4_brk_vec", vec_addr, 16'hFFFE);
    runService();
    nmi_n = 1'b1;
    idle(3);

    // 5: NMI beats IRQ; releasing IRQ in REQ does not cancel
    nmi_n = 1'b0; irq_n = 1'b0; psr_i = 1'b0;
    idle(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_kind", 16'(int_kind), 16'h2);
    checkOutput("t5_break", 16'(break_set), 16'h0);
    irq_n = 1'b1;
    idle(2);
    checkOutput("t5_req_hold", 16'(int_req), 16'h1);
    checkOutput("t5_kind_hold", 16'(int_kind), 16'h2);
    runService();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_no_irq", 16'(int_req), 16'h0);
    nmi_n = 1'b1; psr_i = 1'b1;
    idle(3);

    // 6: reset mid-service aborts strobes and re-arms the reset request
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_vec", vec_addr, 16'hFFFC);
    for (int c = 0; c < 8; c++) begin
      checkOutput("t6_set_i", 16'(set_i), 16'h0);
      checkOutput("t6_done", 16'(svc_done), 16'h0);
      idle(1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_kind", 16'(int_kind), 16'h1);
    checkOutput("t6_req", 16'(int_req), 16'h1);
    runService();

    checking = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
